// File: rtl/qd_mult_gen_if.sv
// qd_mult_gen_if: divisor load, digit and result handshakes for qd_mult_gen.
interface qd_mult_gen_if #(
    parameter int WIDTH = 27,
    parameter int CNT_W = 6
);
    logic               d_load;
    logic [WIDTH-1:0]   d_in;
    logic               d_rdy;
    logic               q_valid;
    logic [3:0]         q_digit;
    logic               q_ready;
    logic               out_valid;
    logic [WIDTH+2:0]   out_data;
    logic               out_ready;
    logic               err;
    logic [CNT_W-1:0]   iter_cnt;
    modport master (
        output d_load, d_in, q_valid, q_digit, out_ready,
        input  d_rdy, q_ready, out_valid, out_data, err, iter_cnt
    );
    modport slave (
        input  d_load, d_in, q_valid, q_digit, out_ready,
        output d_rdy, q_ready, out_valid, out_data, err, iter_cnt
    );
endinterface

// File: rtl/qd_mult_gen.sv
// qd_mult_gen: registered signed q*d multiple generator for radix-4 SRT digits.
module qd_mult_gen #(
    parameter int WIDTH = 27,
    parameter int DMAX  = 3,
    parameter int CNT_W = 6
) (
    input logic         clk,
    input logic         rst,
    qd_mult_gen_if.slave bus
);
    localparam int OUT_W = WIDTH + 3;
    typedef enum logic [1:0] {IDLE, PREP, RUN} state_t;
    state_t             state_q;
    logic [WIDTH-1:0]   d_q;
    logic [WIDTH+1:0]   d3_q;
    logic [OUT_W-1:0]   out_data_q;
    logic               out_valid_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg, illegal, accept;
    logic [3:0]         mag_sel;
    logic [WIDTH+1:0]   mag;
    logic [OUT_W-1:0]   prod_d;
    always_comb begin
        neg     = bus.q_digit[3];
        mag_sel = neg ? 4'd0 - bus.q_digit : bus.q_digit;
        illegal = (bus.q_digit == 4'b1000) || (int'(mag_sel) > DMAX);
        mag     = mag_sel == 4'd1 ? {2'b00, d_q} :
                  mag_sel == 4'd2 ? {1'b0, d_q, 1'b0} :
                  mag_sel == 4'd3 ? d3_q : '0;
        prod_d  = illegal ? '0 : neg ? {OUT_W{1'b0}} - {1'b0, mag} : {1'b0, mag};
        accept  = bus.q_valid && bus.q_ready;
    end
    assign bus.q_ready   = (state_q == RUN) && !bus.d_load && (!out_valid_q || bus.out_ready);
    assign bus.d_rdy     = state_q == RUN;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.err       = err_q;
    assign bus.iter_cnt  = cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            d_q         <= '0;
            d3_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else if (bus.d_load) begin
            state_q     <= PREP;
            d_q         <= bus.d_in;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else if (state_q == PREP) begin
            d3_q    <= ({2'b00, d_q} << 1) + {2'b00, d_q};
            state_q <= RUN;
        end else if (accept) begin
            out_data_q  <= prod_d;
            out_valid_q <= 1'b1;
            err_q       <= err_q | illegal;
            cnt_q       <= &cnt_q ? cnt_q : cnt_q + 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: doc/qd_mult_gen.md
QD_MULT_GEN -- requirements
Module: qd_mult_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 27: divisor width in bits, legal range 8..64.
REQ-002 SHALL have parameter DMAX, default 3: largest legal quotient-digit magnitude, legal values 2 or 3.
REQ-003 SHALL have parameter CNT_W, default 6: width of the iteration counter.
REQ-004 SHALL define derived width OUT_W = WIDTH+3, which holds a signed q*d result.
REQ-005 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- d_load  in  1  captures a new divisor.
- d_in  in  WIDTH  unsigned divisor, sampled when d_load=1.
- d_rdy  out  1  divisor and 3d are ready; digits may be accepted.
- q_valid  in  1  a digit is offered.
- q_digit  in  4  signed two's-complement quotient digit.
- q_ready  out  1  digit accepted when q_valid & q_ready.
- out_valid  out  1  result is held in the output register.
- out_data  out  OUT_W  signed q*d.
- out_ready  in  1  consumer accepts the result.
- err  out  1  sticky flag: an illegal digit was seen.
- iter_cnt  out  CNT_W  number of digits accepted since the last load.

Function
REQ-006 SHALL implement a three-state FSM: IDLE (no divisor), PREP (computing 3d), RUN.
REQ-007 SHALL handle d_load=1 as follows:
- any state goes to PREP next cycle;
- d_in is registered;
- out_valid, err and iter_cnt are cleared next cycle.
REQ-008 SHALL, in PREP with no d_load, register 3d = (d<<1)+d (WIDTH+2 bits) and go to RUN next cycle; PREP always lasts exactly one cycle.
REQ-009 SHALL drive d_rdy = (state==RUN).
REQ-010 SHALL drive q_ready = (state==RUN) & ~d_load & (~out_valid | out_ready).
REQ-011 SHALL, on a digit accept in cycle N, present out_valid=1 with the result in cycle N+1 (latency 1).
REQ-012 SHALL compute out_data as follows:
- digit 0 gives 0;
- digits ±1 give ±d;
- digits ±2 give ±(d<<1);
- digits ±3 give ±3d;
- negation is two's complement over OUT_W bits;
- the result is sign-correct with no truncation.
REQ-013 SHALL treat as illegal any digit with |q_digit| > DMAX, and always the code 4'b1000.
REQ-014 SHALL, on an accepted illegal digit:
- set out_data=0;
- still set out_valid=1;
- set err=1, which holds until reset or d_load.
REQ-015 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-016 SHALL handle out_valid & out_ready with no new accept by clearing out_valid next cycle.
REQ-017 SHALL, on a simultaneous drain and new accept, load the new result and keep out_valid=1, allowing one digit per cycle.
REQ-018 SHALL increment iter_cnt on each accepted digit, saturate at all-ones, and clear it on load.
REQ-019 SHALL ignore q_valid while state is not RUN; no accept occurs and the counter is unchanged.
REQ-020 SHALL give d_load priority over a simultaneous q_valid: q_ready is 0, so the digit is not accepted.
REQ-021 SHALL keep the datapath free of combinational paths from q_digit to any output.

Reset
REQ-022 SHALL, with rst=1 at a rising edge, drive next cycle: state=IDLE, d_rdy=0, q_ready=0, out_valid=0, out_data=0, err=0, iter_cnt=0; the divisor and 3d registers are cleared to 0.
REQ-023 SHALL give rst priority over d_load and handshakes in the same cycle, including mid-PREP and mid-RUN with a pending result, which is discarded.

Verification (WIDTH=27, DMAX=3)
REQ-024 SHALL cover load and negative digit: d_load with d_in=5, then q_digit=-3 accepted the cycle after d_rdy rises -> next cycle out_valid=1, out_data=30'h3FFFFFF1, iter_cnt=1.
REQ-025 SHALL cover maximum magnitude: d_in=27'h7FFFFFF, q_digit=+3 -> out_data=30'h17FFFFFD; q_digit=-2 -> out_data=30'h30000002.
REQ-026 SHALL cover backpressure: out_ready=0 while a result is held and q_valid=1 -> q_ready=0, out_data stable for 5 cycles; out_ready=1 -> next digit accepted the same cycle, giving back-to-back output.
REQ-027 SHALL cover illegal digit: q_digit=+4 -> out_data=0, out_valid=1, err=1 sticky across legal digits; d_load -> err=0 the next cycle.
REQ-028 SHALL cover load mid-run: d_load with q_valid=1 and a result pending -> no accept, out_valid=0 next cycle, iter_cnt=0, one PREP cycle, then d_rdy=1.
REQ-029 SHALL cover reset mid-PREP and saturation: rst during PREP -> IDLE with all outputs 0; 70 accepted digits -> iter_cnt=63 (CNT_W=6).
